// File: rtl/i2c_codec_target.sv
// I2C target receiver for codec register writes: address byte, then 7-bit reg + 9-bit data frames.
// Optional I2C_CODEC_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on scl/sda.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_s;
  logic                   sda_s;

  // Synchronizers reset to the idle-bus level so reset release cannot look like a START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_tap_reg;
  logic [1:0] sda_tap_reg;
  logic       scl_flt_reg;
  logic       sda_flt_reg;
  logic       scl_raw;
  logic       sda_raw;

  assign scl_raw = scl_sync_reg[SYNC_STAGES-1];
  assign sda_raw = sda_sync_reg[SYNC_STAGES-1];

  // Majority of the current sample and two delayed taps; a lone 1-clk pulse never wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_tap_reg <= 2'b11;
      sda_tap_reg <= 2'b11;
      scl_flt_reg <= 1'b1;
      sda_flt_reg <= 1'b1;
    end else begin
      scl_tap_reg <= {scl_tap_reg[0], scl_raw};
      sda_tap_reg <= {sda_tap_reg[0], sda_raw};
      scl_flt_reg <= (scl_raw & scl_tap_reg[0]) | (scl_raw & scl_tap_reg[1]) |
                     (scl_tap_reg[0] & scl_tap_reg[1]);
      sda_flt_reg <= (sda_raw & sda_tap_reg[0]) | (sda_raw & sda_tap_reg[1]) |
                     (sda_tap_reg[0] & sda_tap_reg[1]);
    end
  end

  assign scl_s = scl_flt_reg;
  assign sda_s = sda_flt_reg;
`else
  assign scl_s = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s = sda_sync_reg[SYNC_STAGES-1];
`endif

  logic scl_prev_reg;
  logic sda_prev_reg;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev_reg;
  assign scl_fall  = ~scl_s & scl_prev_reg;
  assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
  assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

  state_t     state_reg;
  logic [2:0] bit_cnt_reg;
  logic [6:0] shift_reg;
  logic [7:0] hi_reg;
  logic [7:0] shifted;

  assign shifted = {shift_reg, sda_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 7'd0;
      hi_reg      <= 8'd0;
      sda_oe      <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= 7'd0;
      wr_data     <= 9'd0;
      busy        <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        state_reg   <= ADDR;
        bit_cnt_reg <= 3'd0;
        busy        <= 1'b1;
        sda_oe      <= 1'b0;
      end else if (stop_det) begin
        state_reg <= IDLE;
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        case (state_reg)
          ADDR: begin
            if (scl_rise) begin
              shift_reg   <= shifted[6:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7)
                state_reg <= (shifted[7:1] == DEV_ADDR && !shifted[0]) ? ADDR_ACK : IGNORE;
            end
          end
          // First fall after the 8th bit pulls SDA; the fall closing the ACK clock releases it.
          ADDR_ACK, ACK_HI, ACK_LO: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe      <= 1'b0;
                bit_cnt_reg <= 3'd0;
                state_reg   <= (state_reg == ACK_HI) ? BYTE_LO : BYTE_HI;
              end
            end
          end
          BYTE_HI: begin
            if (scl_rise) begin
              shift_reg   <= shifted[6:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                hi_reg    <= shifted;
                state_reg <= ACK_HI;
              end
            end
          end
          BYTE_LO: begin
            if (scl_rise) begin
              shift_reg   <= shifted[6:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                wr_addr   <= hi_reg[7:1];
                wr_data   <= {hi_reg[0], shifted};
                wr_valid  <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
                state_reg <= ACK_LO;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for i2c_codec_target: bit-banged initiator, frame queue model, per-cycle compare.
module tb_i2c_codec_target;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  txn[$];
  logic [6:0]  m_addr = 7'd0;
  logic [8:0]  m_data = 9'd0;
  logic [7:0]  m_cnt  = 8'd0;

  i2c_codec_target #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Open-drain bus: low if either side pulls.
  assign sda_in = sda_drv & ~sda_oe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per cycle: each strobe must match the next expected frame; outputs hold between strobes.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_wr_valid", 32'(wr_valid), 32'd0);
        end else begin
          m_addr = exp_q[0][15:9];
          m_data = exp_q[0][8:0];
          m_cnt  = m_cnt + 8'd1;
          void'(exp_q.pop_front());
        end
      end
      check("wr_addr", 32'(wr_addr), 32'(m_addr));
      check("wr_data", 32'(wr_data), 32'(m_data));
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    end
  end

  task automatic send_bit(input logic b, input logic ack_slot, input logic exp_oe);
    sda_drv = b;
    wait_clk(4);
    scl = 1'b1;
    wait_clk(4);
    check(ack_slot ? "ack_sda_oe" : "data_sda_oe", 32'(sda_oe), 32'(exp_oe));
    wait_clk(4);
    scl = 1'b0;
    wait_clk(4);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[7-i], 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    send_bits(b, 8);
    send_bit(1'b1, 1'b1, exp_ack);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    wait_clk(4);
    scl = 1'b1;
    wait_clk(4);
    sda_drv = 1'b0;
    wait_clk(4);
    scl = 1'b0;
    wait_clk(4);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_clk(4);
    scl = 1'b1;
    wait_clk(4);
    sda_drv = 1'b1;
    wait_clk(8);
    check("busy_after_stop", 32'(busy), 32'd0);
    check("sda_oe_after_stop", 32'(sda_oe), 32'd0);
  endtask

  // A write to 0x1A is address byte 0x34; each complete byte pair after it is one frame.
  task automatic run_txn();
    logic addressed;
    i2c_start();
    addressed = (txn[0] == 8'h34);
    send_byte(txn[0], addressed);
    for (int i = 1; i < txn.size(); i++) begin
      if (addressed && (i % 2 == 0)) exp_q.push_back({txn[i-1], txn[i]});
      send_byte(txn[i], addressed);
    end
    i2c_stop();
  endtask

  initial begin
    logic [7:0] rem;
    wait_clk(3);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b1;
    wait_clk(10);

    // Single frame: reg 0x02 <- 0x079.
    txn = '{8'h34, 8'h04, 8'h79};
    run_txn();
    check("t1_addr", 32'(wr_addr), 32'h02);
    check("t1_data", 32'(wr_data), 32'h079);
    check("t1_cnt", 32'(frame_cnt), 32'd1);

    // Codec init set, 11 frames.
    txn = '{8'h34, 8'h00, 8'h97, 8'h02, 8'h97, 8'h04, 8'h79, 8'h06, 8'h79,
            8'h08, 8'h12, 8'h0A, 8'h00, 8'h0C, 8'h00, 8'h0E, 8'h01,
            8'h10, 8'h00, 8'h12, 8'h01, 8'h1E, 8'h00};
    run_txn();
    check("t2_addr", 32'(wr_addr), 32'h0F);
    check("t2_data", 32'(wr_data), 32'h000);
    check("t2_cnt", 32'(frame_cnt), 32'd12);

    // Wrong address, then read bit set: no ACKs, no frames.
    txn = '{8'h36, 8'h04, 8'h79};
    run_txn();
    txn = '{8'h35, 8'h04, 8'h79};
    run_txn();
    check("t4_cnt", 32'(frame_cnt), 32'd12);
    check("t4_addr", 32'(wr_addr), 32'h0F);

    // STOP in the middle of the second byte discards the partial frame.
    i2c_start();
    send_byte(8'h34, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_bits(8'h00, 3);
    i2c_stop();
    check("t5_partial_cnt", 32'(frame_cnt), 32'd12);
    txn = '{8'h34, 8'h0A, 8'h00};
    run_txn();
    check("t5_addr", 32'(wr_addr), 32'h05);
    check("t5_data", 32'(wr_data), 32'h000);
    check("t5_cnt", 32'(frame_cnt), 32'd13);

    // Async reset during BYTE_LO, then the rest of the bus traffic is ignored.
    i2c_start();
    send_byte(8'h34, 1'b1);
    send_byte(8'h04, 1'b1);
    send_bits(8'h79, 3);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    m_addr = 7'd0;
    m_data = 9'd0;
    m_cnt  = 8'd0;
    #1;
    check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
    check("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    wait_clk(3);
    rst = 1'b1;
    rem = 8'h79 << 3;
    send_bits(rem, 5);
    i2c_stop();
    check("t6_ignored_cnt", 32'(frame_cnt), 32'd0);
    txn = '{8'h34, 8'h04, 8'h79};
    run_txn();
    check("t6_addr", 32'(wr_addr), 32'h02);
    check("t6_data", 32'(wr_data), 32'h079);
    check("t6_cnt", 32'(frame_cnt), 32'd1);

    wait_clk(10);
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
